adsr_wave_generator: RTL and testbench
======================================

ADSR_WAVE_GENERATOR -- requirements
Module: adsr_wave_generator

Interface
REQ-001 SHALL have parameter DW, default 8, meaning wave_out width (4..16).
REQ-002 SHALL have parameter PHASE_W, default 24, meaning phase accumulator width (>= DW+1).
REQ-003 SHALL have parameter ENV_W, default 8, meaning envelope level and rate width.
REQ-004 SHALL have parameter PRESCALE, default 256, meaning clocks per envelope tick (>= 1).
REQ-005 SHALL have port clk, input, 1, the single clock (rising edge).
REQ-006 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port phase_inc, input, PHASE_W, the per-clock phase increment that sets the output frequency.
REQ-008 SHALL have port wave_sel, input, 2, waveform select: 0 triangle, 1 saw, 2 square, 3 noise.
REQ-009 SHALL have ports attack_rate, decay_rate, release_rate, input, ENV_W each, level step per envelope tick.
REQ-010 SHALL have port sustain_level, input, ENV_W, the sustain target level.
REQ-011 SHALL have port gate, input, 1, note held while high.
REQ-012 SHALL have port wave_out, output, DW, the enveloped waveform (registered).
REQ-013 SHALL have port env_level, output, ENV_W, the current envelope level.
REQ-014 SHALL have port adsr_state, output, 3, the current envelope state encoding.
REQ-015 SHALL have port busy, output, 1, high whenever adsr_state is not IDLE.

Function
REQ-016 SHALL add phase_inc to the phase accumulator every clock, wrapping modulo 2^PHASE_W; phase_inc=0 freezes phase.
REQ-017 SHALL form the raw waveform as follows: saw = phase[MSB -: DW]; triangle = phase[MSB-1 -: DW], bit-inverted when phase MSB=1; square = all-ones when MSB=0, else 0; noise = top DW bits of a 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1).
REQ-018 SHALL step the LFSR once per phase wrap only.
REQ-019 SHALL use a free-running prescaler that produces a one-clock env_tick every PRESCALE clocks; envelope level changes only on env_tick.
REQ-020 SHALL implement the state machine IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; the other encodings SHALL return to IDLE on the next clock.
REQ-021 SHALL, on a registered gate rising edge in any state, enter ATTACK without clearing the level (retrigger).
REQ-022 SHALL, on gate low in ATTACK, DECAY or SUSTAIN, enter RELEASE on the next clock.
REQ-023 ATTACK: SHALL compute level += attack_rate per tick, saturating at all-ones, then go to DECAY; attack_rate=0 SHALL load all-ones on the next tick.
REQ-024 DECAY: SHALL compute level -= decay_rate per tick, clamped at sustain_level, then go to SUSTAIN; decay_rate=0 SHALL load sustain_level on the next tick.
REQ-025 SUSTAIN: SHALL track sustain_level live, updating level on each tick.
REQ-026 RELEASE: SHALL compute level -= release_rate per tick, saturating at 0, then go to IDLE; release_rate=0 SHALL load 0 on the next tick.
REQ-027 SHALL give a simultaneous gate rising edge and tick priority to the state change; the tick is consumed by the new state.
REQ-028 SHALL compute wave_out = (raw*env_level + raw) >> ENV_W, registered, so that full-scale x full-scale = full-scale and env 0 gives 0.
REQ-029 SHALL update wave_out exactly 1 clock after the phase and level values it uses.

Reset
REQ-030 SHALL, with rst_n low at a clk edge, clear phase, prescaler, level, wave_out and set adsr_state=IDLE, busy=0, LFSR=16'hACE1, registered gate=0.
REQ-031 SHALL, when reset is asserted mid-note, take effect on that edge; gate held high across release of reset SHALL count as a rising edge.

Structure
REQ-032 SHALL place the state encodings and wave_sel constants in shared package adsr_wave_pkg.
REQ-033 SHALL implement the envelope (prescaler, FSM, level) as sub-module adsr_envelope; phase, LFSR and multiply SHALL stay in the top module.

Verification
REQ-034 Saw test: DW=8, PHASE_W=24, phase_inc=2^16, gate constantly high with all rates 255 -> wave_out ramps 0..255 stepping 1 per clock, wraps every 256 clocks.
REQ-035 ADSR test: attack=64, decay=16, sustain=128, release=32, PRESCALE=4 -> level 64,128,192,255 on successive ticks, then 239..128 (clamped), holds, gate low -> 96,64,32,0, IDLE, busy=0.
REQ-036 Retrigger test: gate low then high during RELEASE at level 96 -> ATTACK resumes from 96, not 0.
REQ-037 Noise test: wave_sel=3, phase_inc=2^23 -> LFSR steps every 2 clocks, sequence from 16'hACE1 matches model.
REQ-038 Reset test: rst_n low mid-SUSTAIN -> next edge wave_out=0, env_level=0, adsr_state=0; rst_n must be sampled only at clk edges (no asynchronous clear).
REQ-039 Boundary test: env_level 255 and square wave -> wave_out=255; attack_rate=0 -> level 255 on the first tick.

Source files
------------

// File: rtl/adsr_wave_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adsr_wave_pkg -- envelope state / waveform select encodings, LFSR step. rev 1.0
// ----------------------------------------------------------------------------
package adsr_wave_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [1:0] WAVE_TRI    = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_SQUARE = 2'd2;
  localparam logic [1:0] WAVE_NOISE  = 2'd3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adsr_envelope -- tick prescaler, ADSR state machine and envelope level. rev 1.0
// ----------------------------------------------------------------------------
module adsr_envelope
  import adsr_wave_pkg::*;
#(
  parameter int ENV_W    = 8,
  parameter int PRESCALE = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ENV_W-1:0] attack_rate,
  input  logic [ENV_W-1:0] decay_rate,
  input  logic [ENV_W-1:0] release_rate,
  input  logic [ENV_W-1:0] sustain_level,
  input  logic             gate,
  output logic [ENV_W-1:0] env_level,
  output logic [2:0]       adsr_state,
  output logic             busy
);

  localparam int               CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [ENV_W-1:0] LVL_MAX  = '1;

  logic [2:0]       state, state_next;
  logic [ENV_W-1:0] level, level_next;
  logic [CNT_W-1:0] presc_cnt;
  logic             gate_q, gate_rise, env_tick;
  logic [ENV_W:0]   att_sum, dec_diff, rel_diff;
  logic             att_full, dec_done, rel_done;
  logic [ENV_W-1:0] att_level;

  assign env_tick  = (presc_cnt == CNT_LAST);
  assign gate_rise = gate & ~gate_q;

  // One extra bit catches overflow / borrow of each rate step
  assign att_sum   = {1'b0, level} + {1'b0, attack_rate};
  assign dec_diff  = {1'b0, level} - {1'b0, decay_rate};
  assign rel_diff  = {1'b0, level} - {1'b0, release_rate};
  assign att_full  = (attack_rate == '0) || (att_sum >= {1'b0, LVL_MAX});
  assign att_level = att_full ? LVL_MAX : att_sum[ENV_W-1:0];
  assign dec_done  = (decay_rate == '0) || dec_diff[ENV_W] ||
                     (dec_diff[ENV_W-1:0] <= sustain_level);
  assign rel_done  = (release_rate == '0) || rel_diff[ENV_W] ||
                     (rel_diff[ENV_W-1:0] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      level     <= '0;
      gate_q    <= 1'b0;
      presc_cnt <= '0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      gate_q    <= gate;
      presc_cnt <= env_tick ? '0 : presc_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    level_next = level;
    case (state)
      ST_IDLE: state_next = ST_IDLE;
      ST_ATTACK: begin
        if (env_tick) begin
          level_next = att_level;
          if (att_full) state_next = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (env_tick) begin
          if (dec_done) begin
            level_next = sustain_level;
            state_next = ST_SUSTAIN;
          end else begin
            level_next = dec_diff[ENV_W-1:0];
          end
        end
      end
      ST_SUSTAIN: begin
        if (env_tick) level_next = sustain_level;
      end
      ST_RELEASE: begin
        if (env_tick) begin
          if (rel_done) begin
            level_next = '0;
            state_next = ST_IDLE;
          end else begin
            level_next = rel_diff[ENV_W-1:0];
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A retrigger owns this edge: a coincident tick is spent as an attack step
    if (gate_rise && (state <= ST_RELEASE)) begin
      state_next = (env_tick && att_full) ? ST_DECAY : ST_ATTACK;
      level_next = env_tick ? att_level : level;
    end else if (!gate && ((state == ST_ATTACK) || (state == ST_DECAY) ||
                           (state == ST_SUSTAIN))) begin
      state_next = ST_RELEASE;
    end
  end

  always_comb begin
    env_level  = level;
    adsr_state = state;
    busy       = (state != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: rtl/adsr_wave_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adsr_wave_generator -- phase-accumulator oscillator scaled by an ADSR envelope. rev 1.0
// ----------------------------------------------------------------------------
module adsr_wave_generator
  import adsr_wave_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PHASE_W  = 24,
  parameter int ENV_W    = 8,
  parameter int PRESCALE = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [1:0]         wave_sel,
  input  logic [ENV_W-1:0]   attack_rate,
  input  logic [ENV_W-1:0]   decay_rate,
  input  logic [ENV_W-1:0]   release_rate,
  input  logic [ENV_W-1:0]   sustain_level,
  input  logic               gate,
  output logic [DW-1:0]      wave_out,
  output logic [ENV_W-1:0]   env_level,
  output logic [2:0]         adsr_state,
  output logic               busy
);

  logic [PHASE_W-1:0]   phase;
  logic [PHASE_W:0]     phase_sum;
  logic [15:0]          lfsr;
  logic [DW-1:0]        raw, tri_wave;
  logic [ENV_W:0]       env_p1;
  logic [DW+ENV_W-1:0]  product;

  adsr_envelope #(
    .ENV_W    (ENV_W),
    .PRESCALE (PRESCALE)
  ) u_envelope (
    .clk           (clk),
    .rst_n         (rst_n),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .release_rate  (release_rate),
    .sustain_level (sustain_level),
    .gate          (gate),
    .env_level     (env_level),
    .adsr_state    (adsr_state),
    .busy          (busy)
  );

  assign phase_sum = {1'b0, phase} + {1'b0, phase_inc};
  assign tri_wave  = phase[PHASE_W-2 -: DW];

  always_comb begin
    raw = '0;
    case (wave_sel)
      WAVE_TRI:    raw = phase[PHASE_W-1] ? ~tri_wave : tri_wave;
      WAVE_SAW:    raw = phase[PHASE_W-1 -: DW];
      WAVE_SQUARE: raw = phase[PHASE_W-1] ? '0 : '1;
      WAVE_NOISE:  raw = lfsr[15 -: DW];
    endcase
  end

  // raw*(env+1) keeps full-scale x full-scale at full-scale after the shift
  assign env_p1  = {1'b0, env_level} + (ENV_W+1)'(1);
  assign product = {{ENV_W{1'b0}}, raw} * {{(DW-1){1'b0}}, env_p1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= '0;
      lfsr     <= LFSR_SEED;
      wave_out <= '0;
    end else begin
      phase    <= phase_sum[PHASE_W-1:0];
      if (phase_sum[PHASE_W]) lfsr <= lfsr_next(lfsr);
      wave_out <= DW'(product >> ENV_W);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adsr_wave_generator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adsr_wave_generator -- directed scenarios plus random lockstep model check. rev 1.0
// ----------------------------------------------------------------------------
module tb_adsr_wave_generator;

  localparam int DW       = 8;
  localparam int PHASE_W  = 24;
  localparam int ENV_W    = 8;
  localparam int PRESCALE = 4;
  localparam int PH_MOD   = 1 << PHASE_W;
  localparam int PH_HALF  = 1 << (PHASE_W - 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PHASE_W-1:0] phase_inc = '0;
  logic [1:0]         wave_sel = 2'd1;
  logic [ENV_W-1:0]   attack_rate = '0, decay_rate = '0, release_rate = '0, sustain_level = '0;
  logic               gate = 1'b0;
  logic [DW-1:0]      wave_out;
  logic [ENV_W-1:0]   env_level;
  logic [2:0]         adsr_state;
  logic               busy;

  adsr_wave_generator #(
    .DW(DW), .PHASE_W(PHASE_W), .ENV_W(ENV_W), .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .phase_inc(phase_inc), .wave_sel(wave_sel),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .release_rate(release_rate),
    .sustain_level(sustain_level), .gate(gate), .wave_out(wave_out),
    .env_level(env_level), .adsr_state(adsr_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] actual, input int expected);
    total++;
    if (actual !== 32'(expected)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model: phase as an integer angle, envelope as named-state integer rules
  int unsigned m_phase;
  int m_lfsr, m_cnt, m_level, m_state, m_gate_q, m_wave;

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

  function automatic int lfsr_step(int s);
    return (s & 1) ? ((s >> 1) ^ 'hB400) : (s >> 1);
  endfunction

  function automatic int raw_of(int unsigned ph, int lf, int sel);
    int t;
    t = int'((ph >> 15) & 255);
    case (sel)
      0:       return (ph >= PH_HALF) ? 255 - t : t;
      1:       return int'(ph >> 16);
      2:       return (ph < PH_HALF) ? 255 : 0;
      default: return (lf >> 8) & 255;
    endcase
  endfunction

  task automatic model_step();
    int raw, nl, st, nst, ar, dr, rr, sus;
    bit tick, rise;
    if (!rst_n) begin
      m_phase = 0; m_lfsr = 'hACE1; m_cnt = 0; m_level = 0;
      m_state = 0; m_gate_q = 0; m_wave = 0;
      return;
    end
    ar = int'(attack_rate); dr = int'(decay_rate);
    rr = int'(release_rate); sus = int'(sustain_level);
    raw = raw_of(m_phase, m_lfsr, int'(wave_sel));
    m_wave = (raw * m_level + raw) >> 8;
    if (m_phase + int'(phase_inc) >= PH_MOD) m_lfsr = lfsr_step(m_lfsr);
    m_phase = (m_phase + int'(phase_inc)) % PH_MOD;
    tick  = (m_cnt == PRESCALE - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    rise  = gate && (m_gate_q == 0);
    st  = rise ? 1 : m_state;
    nl  = m_level;
    nst = st;
    if (tick) begin
      case (st)
        1: begin nl = (ar == 0) ? 255 : imin(255, m_level + ar); if (nl == 255) nst = 2; end
        2: begin nl = (dr == 0) ? sus : imax(sus, m_level - dr); if (nl == sus) nst = 3; end
        3: nl = sus;
        4: begin nl = (rr == 0) ? 0 : imax(0, m_level - rr); if (nl == 0) nst = 0; end
        default: ;
      endcase
    end
    if (!gate && st >= 1 && st <= 3) nst = 4;
    m_level = nl; m_state = nst; m_gate_q = int'(gate);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("wave", 32'(wave_out), m_wave);
    check("level", 32'(env_level), m_level);
    check("state", 32'(adsr_state), m_state);
    check("busy", 32'(busy), (m_state != 0) ? 1 : 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (adsr_state != 3'(s) && n < budget) begin cycle(); n++; end
    if (adsr_state != 3'(s)) check("timeout_state", 32'(adsr_state), s);
  endtask

  task automatic wait_level(input int l, input int budget);
    int n = 0;
    while (env_level != 8'(l) && n < budget) begin cycle(); n++; end
    if (env_level != 8'(l)) check("timeout_level", 32'(env_level), l);
  endtask

  int lvl_q[$];
  int exp_adsr[16] = '{64, 128, 192, 255, 239, 223, 207, 191, 175, 159, 143, 128, 96, 64, 32, 0};

  initial begin
    int prev, n;
    int unsigned ph_before;

    // Reset state
    gate = 1'b0;
    rst_n = 1'b0;
    cycle(); cycle();
    check("rst_wave", 32'(wave_out), 0);
    check("rst_level", 32'(env_level), 0);
    check("rst_state", 32'(adsr_state), 0);
    check("rst_busy", 32'(busy), 0);

    // Saw ramp at full envelope
    rst_n = 1'b1;
    phase_inc = 24'(1 << 16); wave_sel = 2'd1;
    attack_rate = 8'd255; decay_rate = 8'd255; release_rate = 8'd255; sustain_level = 8'd255;
    gate = 1'b1;
    repeat (20) cycle();
    prev = int'(wave_out);
    for (int i = 0; i < 300; i++) begin
      cycle();
      check("saw_step", 32'(wave_out), (prev + 1) % 256);
      prev = int'(wave_out);
    end

    // Full ADSR sequence with level recording
    gate = 1'b0;
    do_reset();
    attack_rate = 8'd64; decay_rate = 8'd16; sustain_level = 8'd128; release_rate = 8'd32;
    wave_sel = 2'd0; phase_inc = 24'h012345;
    gate = 1'b1;
    prev = 0;
    n = 0;
    while (adsr_state != 3'd3 && n < 200) begin
      cycle(); n++;
      if (int'(env_level) != prev) begin lvl_q.push_back(int'(env_level)); prev = int'(env_level); end
    end
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (int'(env_level) != prev) begin lvl_q.push_back(int'(env_level)); prev = int'(env_level); end
    end
    gate = 1'b0;
    n = 0;
    while (adsr_state != 3'd0 && n < 200) begin
      cycle(); n++;
      if (int'(env_level) != prev) begin lvl_q.push_back(int'(env_level)); prev = int'(env_level); end
    end
    check("adsr_len", 32'(lvl_q.size()), 16);
    for (int i = 0; i < lvl_q.size() && i < 16; i++)
      check($sformatf("adsr_lvl%0d", i), 32'(lvl_q[i]), exp_adsr[i]);
    check("adsr_idle", 32'(adsr_state), 0);
    check("adsr_busy", 32'(busy), 0);

    // Retrigger from release at level 96
    do_reset();
    gate = 1'b1;
    wait_state(3, 200);
    gate = 1'b0;
    wait_level(96, 50);
    gate = 1'b1;
    cycle();
    check("retrig_state", 32'(adsr_state), 1);
    n = 0;
    while (env_level == 8'd96 && n < 10) begin cycle(); n++; end
    check("retrig_level", 32'(env_level), 160);

    // Noise, and attack_rate=0 reaching full scale on the first tick
    gate = 1'b0;
    do_reset();
    attack_rate = 8'd0; decay_rate = 8'd0; sustain_level = 8'd255;
    wave_sel = 2'd3; phase_inc = 24'(1 << 23);
    gate = 1'b1;
    n = 0;
    while (env_level == 8'd0 && n < 10) begin cycle(); n++; end
    check("att0_first_tick", 32'(env_level), 255);
    repeat (120) cycle();

    // Square at full envelope hits 255 / 0 by phase half
    wave_sel = 2'd2; phase_inc = 24'(1 << 16);
    cycle();
    for (int i = 0; i < 300; i++) begin
      ph_before = m_phase;
      cycle();
      if (ph_before < PH_HALF) check("square_top", 32'(wave_out), 255);
      else                     check("square_bot", 32'(wave_out), 0);
    end

    // Reset mid-sustain: no effect before the edge, full clear at it
    gate = 1'b0;
    do_reset();
    attack_rate = 8'd64; decay_rate = 8'd16; sustain_level = 8'd128; release_rate = 8'd32;
    wave_sel = 2'd0; phase_inc = 24'h0A0000;
    gate = 1'b1;
    wait_state(3, 200);
    repeat (5) cycle();
    rst_n = 1'b0;
    #2;
    check("no_async_clear", 32'(env_level), 128);
    cycle();
    check("rst_mid_wave", 32'(wave_out), 0);
    check("rst_mid_level", 32'(env_level), 0);
    check("rst_mid_state", 32'(adsr_state), 0);
    rst_n = 1'b1;
    cycle();
    check("rise_after_rst", 32'(adsr_state), 1);

    // Randomized lockstep run
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) gate = ~gate;
      if ($urandom_range(0, 63) == 0) begin
        attack_rate   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        decay_rate    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        release_rate  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        sustain_level = 8'($urandom);
        wave_sel      = 2'($urandom);
        case ($urandom_range(0, 3))
          0:       phase_inc = '0;
          1:       phase_inc = 24'(1 << 23);
          default: phase_inc = 24'($urandom_range(0, 1 << 20));
        endcase
      end
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
